// File: rtl/sramwo_wbm.sv
// ============================================================================
// Module   : sramwo_wbm
// Purpose  : Write-only SRAM port to Wishbone B4 pipelined initiator bridge.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module sramwo_wbm #(
    parameter int AW    = 6,
    parameter int DEPTH = 4
) (
    input  logic          clk_i,
    input  logic          rst_n_i,
    input  logic [AW-1:0] sram_addr_i,
    input  logic [31:0]   sram_data_i,
    input  logic          sram_wr_i,
    output logic          sram_full_o,
    output logic          ovf_o,
    output logic          err_o,
    input  logic          clr_i,
    output logic          busy_o,
    output logic          wb_cyc_o,
    output logic          wb_stb_o,
    output logic          wb_we_o,
    output logic [31:0]   wb_adr_o,
    output logic [31:0]   wb_dat_o,
    output logic [3:0]    wb_sel_o,
    input  logic          wb_ack_i,
    input  logic          wb_err_i,
    input  logic          wb_stall_i
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int EW = AW + 32;
    localparam logic [CW-1:0] C_DEPTH = CW'(DEPTH);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACTIVE = 2'd1,
        ST_DRAIN  = 2'd2
    } state_t;

    logic [EW-1:0] mem_q [DEPTH];
    logic [EW-1:0] mem_d [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic [CW-1:0] outst_q, outst_d;
    state_t        state_q, state_d;
    logic          ovf_q, ovf_d;
    logic          err_q, err_d;

    logic          fifo_ne;
    logic          full;
    logic          stb;
    logic          push;
    logic          pop;
    logic          resp;
    logic          wr_drop;
    logic [EW-1:0] head;

    // Strobe depends only on registered state so it can never glitch off an input.
    always_comb begin
        fifo_ne = (count_q != '0);
        full    = (count_q == C_DEPTH);
        stb     = (state_q == ST_ACTIVE) && fifo_ne && (outst_q < C_DEPTH);
        push    = sram_wr_i && !full;
        wr_drop = sram_wr_i && full;
        pop     = stb && !wb_stall_i;
        resp    = (wb_ack_i || wb_err_i) && (outst_q != '0);
    end

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            mem_d[wr_ptr_q] = {sram_addr_i, sram_data_i};
            wr_ptr_d        = wr_ptr_q + PW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end
        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_comb begin
        outst_d = outst_q;
        case ({pop, resp})
            2'b10:   outst_d = outst_q + CW'(1);
            2'b01:   outst_d = outst_q - CW'(1);
            default: outst_d = outst_q;
        endcase
    end

    // A set in the same cycle as a clear wins.
    always_comb begin
        ovf_d = clr_i ? 1'b0 : ovf_q;
        err_d = clr_i ? 1'b0 : err_q;
        if (wr_drop) begin
            ovf_d = 1'b1;
        end
        if (wb_err_i && (outst_q != '0)) begin
            err_d = 1'b1;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (fifo_ne || push) begin
                    state_d = ST_ACTIVE;
                end
            end
            ST_ACTIVE: begin
                if (count_d == '0) begin
                    state_d = (outst_d != '0) ? ST_DRAIN : ST_IDLE;
                end
            end
            ST_DRAIN: begin
                if (count_d != '0) begin
                    state_d = ST_ACTIVE;
                end else if (outst_d == '0) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            outst_q  <= '0;
            state_q  <= ST_IDLE;
            ovf_q    <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            outst_q  <= outst_d;
            state_q  <= state_d;
            ovf_q    <= ovf_d;
            err_q    <= err_d;
        end
    end

    assign head        = mem_q[rd_ptr_q];
    assign wb_cyc_o    = (state_q != ST_IDLE);
    assign wb_we_o     = wb_cyc_o;
    assign wb_stb_o    = stb;
    assign wb_adr_o    = 32'({head[EW-1:32], 2'b00});
    assign wb_dat_o    = head[31:0];
    assign wb_sel_o    = 4'hF;
    assign sram_full_o = full;
    assign ovf_o       = ovf_q;
    assign err_o       = err_q;
    assign busy_o      = fifo_ne || (outst_q != '0);

endmodule

`default_nettype wire

// File: tb/tb_sramwo_wbm.sv
// ============================================================================
// Module   : tb_sramwo_wbm
// Purpose  : Self-checking bench for sramwo_wbm against a queue-based model.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_sramwo_wbm;

    localparam int AW    = 6;
    localparam int DEPTH = 4;

    logic          clk = 1'b0;
    logic          rst_n_i = 1'b0;
    logic [AW-1:0] sram_addr_i = '0;
    logic [31:0]   sram_data_i = '0;
    logic          sram_wr_i = 1'b0;
    logic          sram_full_o, ovf_o, err_o, busy_o;
    logic          clr_i = 1'b0;
    logic          wb_cyc_o, wb_stb_o, wb_we_o;
    logic [31:0]   wb_adr_o, wb_dat_o;
    logic [3:0]    wb_sel_o;
    logic          wb_ack_i = 1'b0, wb_err_i = 1'b0, wb_stall_i = 1'b0;

    sramwo_wbm #(.AW(AW), .DEPTH(DEPTH)) dut (
        .clk_i(clk), .rst_n_i(rst_n_i),
        .sram_addr_i(sram_addr_i), .sram_data_i(sram_data_i), .sram_wr_i(sram_wr_i),
        .sram_full_o(sram_full_o), .ovf_o(ovf_o), .err_o(err_o), .clr_i(clr_i),
        .busy_o(busy_o), .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o), .wb_we_o(wb_we_o),
        .wb_adr_o(wb_adr_o), .wb_dat_o(wb_dat_o), .wb_sel_o(wb_sel_o),
        .wb_ack_i(wb_ack_i), .wb_err_i(wb_err_i), .wb_stall_i(wb_stall_i)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Model: queue of buffered writes, count of beats awaiting a response, sticky flags.
    logic [AW+31:0] mq[$];
    int             m_outst = 0;
    bit             m_ovf = 0;
    bit             m_err = 0;

    function automatic bit m_stb();
        return (mq.size() > 0) && (m_outst < DEPTH);
    endfunction

    function automatic bit m_busy();
        return (mq.size() > 0) || (m_outst > 0);
    endfunction

    function automatic logic [31:0] m_adr();
        logic [AW+31:0] e;
        e = mq[0];
        return 32'({e[AW+31:32], 2'b00});
    endfunction

    function automatic logic [31:0] m_dat();
        logic [AW+31:0] e;
        e = mq[0];
        return e[31:0];
    endfunction

    task automatic model_clear();
        mq.delete();
        m_outst = 0;
        m_ovf   = 0;
        m_err   = 0;
    endtask

    // Drive one cycle of inputs, advance the model across the edge, settle.
    task automatic tick(input bit wr, input logic [AW-1:0] a, input logic [31:0] d,
                        input bit ack, input bit err, input bit stall, input bit clr);
        bit acc, rsp, was_full;
        sram_wr_i   = wr;
        sram_addr_i = a;
        sram_data_i = d;
        wb_ack_i    = ack;
        wb_err_i    = err;
        wb_stall_i  = stall;
        clr_i       = clr;
        @(posedge clk);
        acc      = m_stb() && !stall;
        rsp      = (ack || err) && (m_outst > 0);
        was_full = (mq.size() == DEPTH);
        if (clr) begin
            m_ovf = 0;
            m_err = 0;
        end
        if (wr && was_full) m_ovf = 1;
        if (err && m_outst > 0) m_err = 1;
        if (acc) void'(mq.pop_front());
        if (wr && !was_full) mq.push_back({a, d});
        m_outst = m_outst + (acc ? 1 : 0) - (rsp ? 1 : 0);
        #1;
        sram_wr_i = 1'b0;
        wb_ack_i  = 1'b0;
        wb_err_i  = 1'b0;
        clr_i     = 1'b0;
    endtask

    task automatic do_reset();
        rst_n_i    = 1'b0;
        wb_stall_i = 1'b0;
        model_clear();
        repeat (2) @(posedge clk);
        #1 rst_n_i = 1'b1;
    endtask

    task automatic test_reset();
        rst_n_i = 1'b0;
        model_clear();
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({wb_cyc_o, wb_stb_o, wb_we_o, sram_full_o, ovf_o, err_o, busy_o} !== 7'b0) begin
            errors++;
            $display("FAIL reset_ctrl: got %b required 0000000",
                     {wb_cyc_o, wb_stb_o, wb_we_o, sram_full_o, ovf_o, err_o, busy_o});
        end
        checks++;
        if (wb_adr_o !== 32'h0 || wb_dat_o !== 32'h0 || wb_sel_o !== 4'hF) begin
            errors++;
            $display("FAIL reset_bus: adr %h dat %h sel %h required 0 0 F", wb_adr_o, wb_dat_o, wb_sel_o);
        end
        rst_n_i = 1'b1;
    endtask

    task automatic test_single();
        do_reset();
        tick(1, 6'h05, 32'hDEADBEEF, 0, 0, 0, 0);
        checks++;
        if ({wb_cyc_o, wb_stb_o, wb_we_o} !== 3'b111 || wb_adr_o !== 32'h14 ||
            wb_dat_o !== 32'hDEADBEEF || wb_sel_o !== 4'hF) begin
            errors++;
            $display("FAIL single_beat: cyc/stb/we %b adr %h dat %h sel %h required 111 14 deadbeef f",
                     {wb_cyc_o, wb_stb_o, wb_we_o}, wb_adr_o, wb_dat_o, wb_sel_o);
        end
        tick(0, '0, '0, 0, 0, 0, 0);
        checks++;
        if (wb_stb_o !== 1'b0 || wb_cyc_o !== 1'b1) begin
            errors++;
            $display("FAIL single_wait: stb %b cyc %b required 0 1", wb_stb_o, wb_cyc_o);
        end
        tick(0, '0, '0, 1, 0, 0, 0);
        checks++;
        if (wb_cyc_o !== 1'b0 || busy_o !== 1'b0) begin
            errors++;
            $display("FAIL single_end: cyc %b busy %b required 0 0", wb_cyc_o, busy_o);
        end
    endtask

    task automatic test_back_to_back();
        logic [AW-1:0] wa [4];
        logic [31:0]   wd [4];
        int            k = 0;
        do_reset();
        for (int i = 0; i < 4; i++) begin
            wa[i] = AW'($urandom);
            wd[i] = $urandom;
        end
        for (int c = 0; c < 10; c++) begin
            if (c >= 1 && c <= 4) begin
                checks++;
                if (wb_stb_o !== 1'b1 || wb_adr_o !== 32'({wa[c-1], 2'b00}) || wb_dat_o !== wd[c-1]) begin
                    errors++;
                    $display("FAIL b2b_beat%0d: stb %b adr %h dat %h required 1 %h %h", c - 1,
                             wb_stb_o, wb_adr_o, wb_dat_o, 32'({wa[c-1], 2'b00}), wd[c-1]);
                end
            end
            if (wb_stb_o === 1'b1) k++;
            checks++;
            if (sram_full_o !== 1'b0) begin
                errors++;
                $display("FAIL b2b_full: got %b required 0", sram_full_o);
            end
            tick(c < 4, (c < 4) ? wa[c] : '0, (c < 4) ? wd[c] : '0, m_outst > 0, 0, 0, 0);
        end
        checks++;
        if (k !== 4 || wb_cyc_o !== 1'b0 || busy_o !== 1'b0) begin
            errors++;
            $display("FAIL b2b_count: beats %0d cyc %b busy %b required 4 0 0", k, wb_cyc_o, busy_o);
        end
    endtask

    task automatic test_overflow();
        int nb = 0;
        do_reset();
        for (int i = 0; i < 6; i++) begin
            tick(1, AW'(i + 8), $urandom, 0, 0, 1, 0);
            checks++;
            if (sram_full_o !== (i >= 3) || ovf_o !== (i >= 4)) begin
                errors++;
                $display("FAIL ovf_fill%0d: full %b ovf %b required %b %b", i, sram_full_o, ovf_o,
                         i >= 3, i >= 4);
            end
        end
        for (int c = 0; c < 12; c++) begin
            if (wb_stb_o === 1'b1) nb++;
            tick(0, '0, '0, m_outst > 0, 0, 0, 0);
        end
        checks++;
        if (nb !== 4 || busy_o !== 1'b0 || ovf_o !== 1'b1) begin
            errors++;
            $display("FAIL ovf_drain: beats %0d busy %b ovf %b required 4 0 1", nb, busy_o, ovf_o);
        end
        tick(0, '0, '0, 0, 0, 0, 1);
        checks++;
        if (ovf_o !== 1'b0) begin
            errors++;
            $display("FAIL ovf_clear: got %b required 0", ovf_o);
        end
    endtask

    task automatic test_error();
        int nb = 0, nr = 0;
        bit seen_end = 0;
        do_reset();
        for (int c = 0; c < 12; c++) begin
            bit r;
            if (wb_stb_o === 1'b1) nb++;
            r = (m_outst > 0) && (c % 2 == 0);
            tick(c < 3, AW'(c + 1), 32'hA000_0000 + c, r && nr != 1, r && nr == 1, 0, 0);
            if (r) nr++;
            if (r && nr == 3 && !seen_end) begin
                seen_end = 1;
                checks++;
                if (wb_cyc_o !== 1'b0) begin
                    errors++;
                    $display("FAIL err_cyc_end: cyc %b required 0", wb_cyc_o);
                end
            end
        end
        checks++;
        if (nb !== 3 || err_o !== 1'b1 || wb_cyc_o !== 1'b0 || !seen_end) begin
            errors++;
            $display("FAIL err_result: beats %0d err %b cyc %b ended %b required 3 1 0 1",
                     nb, err_o, wb_cyc_o, seen_end);
        end
        tick(0, '0, '0, 0, 0, 0, 1);
        checks++;
        if (err_o !== 1'b0) begin
            errors++;
            $display("FAIL err_clear: got %b required 0", err_o);
        end
    endtask

    task automatic test_outst_cap();
        int nb = 0;
        do_reset();
        for (int c = 0; c < 8; c++) begin
            if (wb_stb_o === 1'b1) nb++;
            tick(c < DEPTH + 1, AW'(c), $urandom, 0, 0, 0, 0);
        end
        checks++;
        if (nb !== DEPTH || wb_stb_o !== 1'b0 || wb_cyc_o !== 1'b1) begin
            errors++;
            $display("FAIL cap_hold: beats %0d stb %b cyc %b required %0d 0 1", nb, wb_stb_o, wb_cyc_o, DEPTH);
        end
        nb = 0;
        tick(0, '0, '0, 1, 0, 0, 0);
        for (int c = 0; c < 3; c++) begin
            if (wb_stb_o === 1'b1) nb++;
            tick(0, '0, '0, 0, 0, 0, 0);
        end
        checks++;
        if (nb !== 1 || wb_stb_o !== 1'b0) begin
            errors++;
            $display("FAIL cap_release: beats %0d stb %b required 1 0", nb, wb_stb_o);
        end
        for (int c = 0; c < 8; c++) tick(0, '0, '0, 1, 0, 0, 0);
        checks++;
        if (wb_cyc_o !== 1'b0 || busy_o !== 1'b0) begin
            errors++;
            $display("FAIL cap_end: cyc %b busy %b required 0 0", wb_cyc_o, busy_o);
        end
    endtask

    task automatic test_reset_mid();
        int nb = 0;
        do_reset();
        tick(1, 6'h01, 32'h1111_1111, 0, 0, 0, 0);
        tick(1, 6'h02, 32'h2222_2222, 0, 0, 0, 0);
        tick(1, 6'h03, 32'h3333_3333, 0, 0, 0, 0);
        tick(1, 6'h04, 32'h4444_4444, 0, 0, 1, 0);
        checks++;
        if (wb_cyc_o !== 1'b1 || wb_stb_o !== 1'b1 || busy_o !== 1'b1) begin
            errors++;
            $display("FAIL rstmid_setup: cyc %b stb %b busy %b required 1 1 1", wb_cyc_o, wb_stb_o, busy_o);
        end
        #2 rst_n_i = 1'b0;
        #1;
        checks++;
        if (wb_cyc_o !== 1'b0 || wb_stb_o !== 1'b0) begin
            errors++;
            $display("FAIL rstmid_async: cyc %b stb %b required 0 0", wb_cyc_o, wb_stb_o);
        end
        model_clear();
        @(posedge clk);
        #1 rst_n_i = 1'b1;
        for (int c = 0; c < 6; c++) begin
            if (wb_stb_o === 1'b1 || wb_cyc_o === 1'b1) nb++;
            tick(0, '0, '0, 1, 0, 0, 0);
        end
        checks++;
        if (nb !== 0 || busy_o !== 1'b0) begin
            errors++;
            $display("FAIL rstmid_after: active cycles %0d busy %b required 0 0", nb, busy_o);
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int c = 0; c < 400; c++) begin
            bit wr, st, rs, er, cl;
            wr = ($urandom_range(0, 99) < 55);
            st = ($urandom_range(0, 99) < 30);
            rs = (m_outst > 0) ? ($urandom_range(0, 99) < 45) : ($urandom_range(0, 99) < 5);
            er = rs && ($urandom_range(0, 99) < 10);
            cl = ($urandom_range(0, 99) < 4);
            if (c >= 360) begin
                wr = 0;
                st = 0;
                rs = (m_outst > 0);
            end
            tick(wr, AW'($urandom), $urandom, rs && !er, er, st, cl);
            checks++;
            if (wb_stb_o !== m_stb() || wb_cyc_o !== m_busy() || wb_we_o !== m_busy() ||
                busy_o !== m_busy() || sram_full_o !== (mq.size() == DEPTH) ||
                ovf_o !== m_ovf || err_o !== m_err) begin
                errors++;
                $display("FAIL rand_ctrl@%0d: stb %b cyc %b we %b busy %b full %b ovf %b err %b required %b %b %b %b %b %b %b",
                         c, wb_stb_o, wb_cyc_o, wb_we_o, busy_o, sram_full_o, ovf_o, err_o,
                         m_stb(), m_busy(), m_busy(), m_busy(), mq.size() == DEPTH, m_ovf, m_err);
            end
            if (m_stb()) begin
                checks++;
                if (wb_adr_o !== m_adr() || wb_dat_o !== m_dat()) begin
                    errors++;
                    $display("FAIL rand_head@%0d: adr %h dat %h required %h %h",
                             c, wb_adr_o, wb_dat_o, m_adr(), m_dat());
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_overflow();
        test_error();
        test_outst_cap();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/sramwo_wbm.md
# sramwo_wbm

Write-only SRAM-port-to-Wishbone initiator bridge. A register-bank side drives a simple SRAM write port (address, data, one-cycle write strobe); the block buffers each write in a small FIFO and replays it as a Wishbone B4 pipelined single-write transaction on a 32-bit master port. It sits between a generated write-only memory interface and a downstream Wishbone crossbar. It is the initiator counterpart of the Wishbone-slave-to-SRAM write path.

## Interface
- `AW`, default 6: word-address width; the address covers byte bits [AW+1:2].
- `DEPTH`, default 4: FIFO entries (power of 2, ≥2); also the maximum number of outstanding Wishbone transfers.

Ports (name, direction, width, meaning):
- `clk_i`  in  1  single clock; all logic is on its rising edge
- `rst_n_i`  in  1  reset, asynchronous assert, active-low
- `sram_addr_i`  in  AW  word address of the write
- `sram_data_i`  in  32  write data
- `sram_wr_i`  in  1  write strobe; one write per high cycle
- `sram_full_o`  out  1  FIFO full; writes are dropped while high
- `ovf_o`  out  1  sticky: a write was dropped
- `err_o`  out  1  sticky: a transfer ended with `wb_err_i`
- `clr_i`  in  1  synchronous clear of `ovf_o` and `err_o`
- `busy_o`  out  1  FIFO non-empty or any transfer outstanding
- `wb_cyc_o`, `wb_stb_o`, `wb_we_o`  out  1 each  Wishbone master controls
- `wb_adr_o`  out  32  byte address: zero-extended `{addr, 2'b00}`
- `wb_dat_o`  out  32  write data
- `wb_sel_o`  out  4  constant 4'hF
- `wb_ack_i`, `wb_err_i`, `wb_stall_i`  in  1 each  Wishbone slave responses

## Operation
- **FIFO.** Entries are {addr, data}. Push happens when `sram_wr_i` is high and the registered count is below DEPTH. `sram_full_o` = (count == DEPTH).
  - A write while full is dropped and sets `ovf_o`. This holds even if a pop occurs in the same cycle.
  - Pop happens on an accepted beat: `wb_stb_o & ~wb_stall_i`.
  - Simultaneous push and pop leaves the count unchanged.
  - Pointers wrap modulo DEPTH.
- **Outstanding counter** `outst`, range 0..DEPTH:
  - +1 on each accepted beat.
  - −1 on each `wb_ack_i` or `wb_err_i` while `outst > 0`.
  - Both in the same cycle: no change.
  - A response while `outst == 0` is ignored; the counter never underflows.
- **FSM states** IDLE, ACTIVE, DRAIN. `wb_cyc_o` = (state != IDLE).
  - IDLE → ACTIVE when the FIFO is non-empty or a push occurs this cycle.
  - ACTIVE → DRAIN when the FIFO becomes empty next cycle and `outst_next > 0`.
  - ACTIVE → IDLE when the FIFO becomes empty next cycle and `outst_next == 0`.
  - DRAIN → ACTIVE when the FIFO becomes non-empty.
  - DRAIN → IDLE when `outst_next == 0` and the FIFO is empty.
- **Master outputs.**
  - `wb_stb_o` = (state == ACTIVE) & FIFO non-empty & (`outst` < DEPTH). It is decoded from registers only.
  - `wb_adr_o` and `wb_dat_o` show the FIFO head. `wb_we_o` = `wb_cyc_o`.
- **Errors.** `wb_err_i` ends a beat like an ack. The entry is not retried and `err_o` is set.
  - `clr_i` clears both sticky flags. If an error or overflow occurs in the same cycle as `clr_i`, setting wins.
- **`busy_o`** = FIFO non-empty | (`outst` != 0).

## Timing
- **Reset values:**
  - `wb_cyc_o`, `wb_stb_o`, `wb_we_o` = 0
  - `wb_adr_o`, `wb_dat_o` = 0
  - `wb_sel_o` = 4'hF
  - `sram_full_o`, `ovf_o`, `err_o`, `busy_o` = 0
  - FIFO empty, `outst` = 0, state IDLE
- **Reset mid-transaction:** `cyc` and `stb` drop immediately (asynchronously). FIFO contents and outstanding beats are discarded.
- **Latency:** `sram_wr_i` high in cycle N (empty FIFO, IDLE) → `wb_cyc_o`/`wb_stb_o` high in cycle N+1 carrying that entry.
- **Throughput:** with `wb_stall_i` = 0 the block sustains one beat per cycle, back-to-back, as long as the FIFO holds data.
- **Stall:** while `wb_stall_i` = 1, `stb`, `adr` and `dat` hold stable.
- **Response delay:** responses may arrive any number of cycles after the beat, including in the cycle right after acceptance.
- **End of cycle:** `cyc` deasserts in the cycle after the last response, provided the FIFO is empty.
- **Outstanding limit:** when `outst` == DEPTH, `stb` deasserts until a response arrives.

## Test plan
- **Single write.** Write addr 0x05, data 0xDEADBEEF, slave acks one cycle after the beat.
  - Next cycle: `cyc=stb=we=1`, `adr=0x14`, `dat=0xDEADBEEF`, `sel=F`.
  - One beat only; `cyc` low after the ack; `busy_o` then 0.
- **Burst with no stall.** Four writes in consecutive cycles, acks in consecutive cycles.
  - Four back-to-back beats in write order.
  - `outst` peaks at 1–2; `sram_full_o` never asserts.
- **Overflow.** `wb_stall_i` = 1 held; six writes.
  - `sram_full_o` high after the 4th write; writes 5–6 dropped; `ovf_o` = 1.
  - Release stall: exactly four beats issue, then `clr_i` clears `ovf_o`.
- **Error.** Second of three beats answered with `wb_err_i`.
  - All three beats still issue; `err_o` = 1; `cyc` drops after the third ack; no retry of beat 2.
- **Outstanding cap.** Slave withholds acks.
  - `stb` drops after DEPTH accepted beats while `cyc` stays high.
  - One ack → exactly one more beat.
- **Reset mid-burst.** Assert `rst_n_i` low while `outst` = 2 and the FIFO holds 2 entries.
  - `cyc`/`stb` go 0 at once.
  - After release, `busy_o` = 0 and no beats issue.
